// File: rtl/pc_update_unit.sv
// Program-counter stage: sequential or redirect flow, frozen on memory stall, with a
// stalled redirect held until release. Optional taken counter under PC_TAKEN_COUNT_EN.
module pc_update_unit #(
    parameter int                  PC_WIDTH  = 32,
    parameter int                  OFF_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_busywait,
    input  logic                 i_pc_sel,
    input  logic [OFF_WIDTH-1:0] i_offset,
    output logic [PC_WIDTH-1:0]  o_pc,
    output logic [PC_WIDTH-1:0]  o_pc_next4,
    output logic                 o_redirect_pending
`ifdef PC_TAKEN_COUNT_EN
    ,
    output logic [15:0]          o_taken_count
`endif
);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t                r_state;
    logic [PC_WIDTH-1:0]   r_pc;
    logic [PC_WIDTH-1:0]   r_pend_tgt;
    logic [PC_WIDTH-1:0]   w_off_ext;
    logic [PC_WIDTH-1:0]   w_tgt;

    // Word offset is sign-extended to full width; the sum wraps silently.
    assign w_off_ext  = {{(PC_WIDTH-OFF_WIDTH){i_offset[OFF_WIDTH-1]}}, i_offset};
    assign o_pc_next4 = r_pc + PC_WIDTH'(4);
    assign w_tgt      = o_pc_next4 + (w_off_ext << 2);

    assign o_pc               = r_pc;
    assign o_redirect_pending = (r_state == PENDING);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc       <= RESET_PC;
            r_state    <= IDLE;
            r_pend_tgt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_busywait) begin
                        if (i_pc_sel) begin
                            r_pend_tgt <= w_tgt;
                            r_state    <= PENDING;
                        end
                    end else if (i_pc_sel) begin
                        r_pc <= w_tgt;
                    end else begin
                        r_pc <= o_pc_next4;
                    end
                end
                PENDING: begin
                    // First captured target wins; inputs are ignored until release.
                    if (!i_busywait) begin
                        r_pc    <= r_pend_tgt;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef PC_TAKEN_COUNT_EN
    logic        w_taken;
    logic [15:0] r_taken_count;

    assign w_taken = !i_busywait && ((r_state == PENDING) || i_pc_sel);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_taken_count <= '0;
        end else if (w_taken && (r_taken_count != 16'hFFFF)) begin
            r_taken_count <= r_taken_count + 16'd1;
        end
    end

    assign o_taken_count = r_taken_count;
`endif

endmodule

// File: tb/tb_pc_update_unit.sv
// Scoreboard bench for pc_update_unit: a reference model pushes expected state per
// driven cycle, popped and compared one cycle later. Counter checks need PC_TAKEN_COUNT_EN.
module tb_pc_update_unit;

    logic        clock;
    logic        reset;
    logic        busywait;
    logic        pcSel;
    logic [7:0]  offset;
    logic [31:0] pc;
    logic [31:0] pcNext4;
    logic        redirectPending;
`ifdef PC_TAKEN_COUNT_EN
    logic [15:0] takenCount;
`endif

    typedef struct {
        logic [31:0] pc;
        logic        pend;
        logic [15:0] cnt;
    } expect_t;

    expect_t     expQ[$];
    int          checks = 0;
    int          errors = 0;

    logic [31:0] mPc;
    logic        mPend;
    logic [31:0] mPendTgt;
    logic [15:0] mCount;

    pc_update_unit dut (
        .i_clk              (clock),
        .i_reset            (reset),
        .i_busywait         (busywait),
        .i_pc_sel           (pcSel),
        .i_offset           (offset),
        .o_pc               (pc),
        .o_pc_next4         (pcNext4),
        .o_redirect_pending (redirectPending)
`ifdef PC_TAKEN_COUNT_EN
        ,
        .o_taken_count      (takenCount)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive one cycle at the falling edge, advance the model, compare after the rising edge.
    task automatic applyStimulus(input logic rst, input logic busy, input logic sel, input logic [7:0] off);
        logic [31:0] tgt;
        expect_t     e;
        expect_t     got;
        @(negedge clock);
        reset    = rst;
        busywait = busy;
        pcSel    = sel;
        offset   = off;
        tgt = mPc + 32'd4 + {{22{off[7]}}, off, 2'b00};
        if (rst) begin
            mPc = 32'd0; mPend = 1'b0; mPendTgt = 32'd0; mCount = 16'd0;
        end else if (!mPend) begin
            if (busy) begin
                if (sel) begin
                    mPendTgt = tgt;
                    mPend    = 1'b1;
                end
            end else if (sel) begin
                mPc = tgt;
                if (mCount != 16'hFFFF) mCount = mCount + 16'd1;
            end else begin
                mPc = mPc + 32'd4;
            end
        end else if (!busy) begin
            mPc   = mPendTgt;
            mPend = 1'b0;
            if (mCount != 16'hFFFF) mCount = mCount + 16'd1;
        end
        e.pc = mPc; e.pend = mPend; e.cnt = mCount;
        expQ.push_back(e);
        @(posedge clock);
        #1;
        got = expQ.pop_front();
        checkOutput("pc", pc, got.pc);
        checkOutput("pcNext4", pcNext4, got.pc + 32'd4);
        checkOutput("pending", {31'd0, redirectPending}, {31'd0, got.pend});
`ifdef PC_TAKEN_COUNT_EN
        checkOutput("takenCount", {16'd0, takenCount}, {16'd0, got.cnt});
`endif
    endtask

    initial begin
        reset = 1'b1; busywait = 1'b0; pcSel = 1'b0; offset = 8'h00;
        mPc = 32'd0; mPend = 1'b0; mPendTgt = 32'd0; mCount = 16'd0;

        applyStimulus(1, 0, 0, 8'h00);
        applyStimulus(1, 1, 1, 8'h55);
        checkOutput("resetPc", pc, 32'd0);
        checkOutput("resetNext4", pcNext4, 32'd4);
        checkOutput("resetPending", {31'd0, redirectPending}, 32'd0);

        applyStimulus(0, 0, 0, 8'h00); checkOutput("seq4", pc, 32'd4);
        applyStimulus(0, 0, 0, 8'h00); checkOutput("seq8", pc, 32'd8);
        applyStimulus(0, 0, 0, 8'h00); checkOutput("seq12", pc, 32'd12);

        applyStimulus(1, 0, 0, 8'h00);
        applyStimulus(0, 0, 0, 8'h00);
        applyStimulus(0, 0, 0, 8'h00);
        applyStimulus(0, 0, 1, 8'h03); checkOutput("fwdBranch", pc, 32'd24);
        applyStimulus(0, 0, 1, 8'hFE); checkOutput("backBranch", pc, 32'd20);
        applyStimulus(0, 0, 1, 8'hFE); checkOutput("toSixteen", pc, 32'd16);

        applyStimulus(0, 1, 1, 8'h02);
        checkOutput("stallHold", pc, 32'd16);
        checkOutput("stallPend", {31'd0, redirectPending}, 32'd1);
        applyStimulus(0, 1, 1, 8'h05);
        applyStimulus(0, 1, 0, 8'h05);
        checkOutput("stallHold3", pc, 32'd16);
        applyStimulus(0, 0, 1, 8'h07);
        checkOutput("releasePc", pc, 32'd28);
        checkOutput("releasePend", {31'd0, redirectPending}, 32'd0);
        applyStimulus(0, 0, 0, 8'h00); checkOutput("afterRelease", pc, 32'd32);

        applyStimulus(0, 1, 1, 8'h02);
        applyStimulus(1, 1, 1, 8'h02);
        checkOutput("rstPendPc", pc, 32'd0);
        checkOutput("rstPendFlag", {31'd0, redirectPending}, 32'd0);
        applyStimulus(0, 0, 0, 8'h00); checkOutput("discarded", pc, 32'd4);

        applyStimulus(1, 0, 0, 8'h00);
        applyStimulus(0, 0, 1, 8'hFE); checkOutput("toTop", pc, 32'hFFFFFFFC);
        applyStimulus(0, 0, 0, 8'h00); checkOutput("wrapZero", pc, 32'd0);
        applyStimulus(0, 0, 1, 8'h80); checkOutput("minOffset", pc, 32'hFFFFFE04);

        for (int i = 0; i < 60; i++) begin
            applyStimulus(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
        end

`ifdef PC_TAKEN_COUNT_EN
        applyStimulus(1, 0, 0, 8'h00);
        applyStimulus(0, 0, 1, 8'h01);
        applyStimulus(0, 0, 1, 8'h01);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 1, 8'h02);
            applyStimulus(0, 0, 0, 8'h00);
        end
        checkOutput("count5", {16'd0, takenCount}, 32'd5);
        for (int i = 0; i < 65535; i++) begin
            applyStimulus(0, 0, 1, 8'h00);
        end
        checkOutput("countSat", {16'd0, takenCount}, 32'h0000FFFF);
        applyStimulus(0, 1, 1, 8'h00);
        applyStimulus(0, 0, 0, 8'h00);
        checkOutput("countHold", {16'd0, takenCount}, 32'h0000FFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
